// File: rtl/alu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg: shared ALU op, class, funct and FSM encodings
// Rev 1.0
// ------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLL   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_SLTU  = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [2:0] OP_R   = 3'b000;
   localparam logic [2:0] OP_I   = 3'b001;
   localparam logic [2:0] OP_LUI = 3'b010;
   localparam logic [2:0] OP_BR  = 3'b011;
   localparam logic [2:0] OP_LS  = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // funct3 mapping shared by R-type (funct7=0) and I-type arithmetic
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_md_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_control_md_if: instruction fields/operands in, decode and M results out
// Rev 1.0
// ------------------------------------------------------------------
interface alu_control_md_if #(
   parameter int XLEN = 32
);
   logic [6:0]      funct7_i;
   logic [2:0]      ALU_Op_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [3:0]      ALU_Operation_o;
   logic            md_select_o;
   logic [XLEN-1:0] md_result_o;
   logic            stall_o;
   logic            illegal_o;

   modport master (
      output funct7_i, ALU_Op_i, funct3_i, rs1_data_i, rs2_data_i,
      input  ALU_Operation_o, md_select_o, md_result_o, stall_o, illegal_o
   );

   modport slave (
      input  funct7_i, ALU_Op_i, funct3_i, rs1_data_i, rs2_data_i,
      output ALU_Operation_o, md_select_o, md_result_o, stall_o, illegal_o
   );
endinterface
`default_nettype wire

// File: rtl/md_iter_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// md_iter_unit: shift-add multiplier / restoring divider datapath, one bit per step
// Rev 1.0
// ------------------------------------------------------------------
module md_iter_unit
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            step_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [XLEN-1:0] result_o
);
   logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opb_q, opb_d, rs1_q, rs1_d;
   logic [2:0]        f3_q, f3_d;
   logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic              a_sgn_w, b_sgn_w;
   logic [XLEN:0]     sum_w, shifted_w, diff_w;
   logic [2*XLEN-1:0] prod_w;
   logic [XLEN-1:0]   quo_w, rem_w;

   always_comb begin
      a_sgn_w   = rs1_i[XLEN-1] && (funct3_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
      b_sgn_w   = rs2_i[XLEN-1] && (funct3_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
      sum_w     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      shifted_w = {acc_q, lo_q[XLEN-1]};
      diff_w    = shifted_w - {1'b0, opb_q};
      acc_d     = acc_q;
      lo_d      = lo_q;
      opb_d     = opb_q;
      rs1_d     = rs1_q;
      f3_d      = f3_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      if (start_i) begin
         // lo holds multiplier or dividend magnitude, opb the multiplicand or divisor
         acc_d   = '0;
         lo_d    = a_sgn_w ? -rs1_i : rs1_i;
         opb_d   = b_sgn_w ? -rs2_i : rs2_i;
         rs1_d   = rs1_i;
         f3_d    = funct3_i;
         a_neg_d = a_sgn_w;
         b_neg_d = b_sgn_w;
      end else if (step_i) begin
         if (f3_q[2]) begin
            acc_d = diff_w[XLEN] ? shifted_w[XLEN-1:0] : diff_w[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~diff_w[XLEN]};
         end else begin
            acc_d = sum_w[XLEN:1];
            lo_d  = {sum_w[0], lo_q[XLEN-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         rs1_q   <= '0;
         f3_q    <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         rs1_q   <= rs1_d;
         f3_q    <= f3_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
      end
   end

   // Sign correction; divide-by-zero bypasses it to keep the raw dividend
   always_comb begin
      prod_w = {acc_q, lo_q};
      if (a_neg_q ^ b_neg_q) prod_w = -prod_w;
      quo_w  = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
      rem_w  = a_neg_q ? -acc_q : acc_q;
      case (f3_q)
         MD_MUL:                          result_o = prod_w[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:    result_o = prod_w[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:                 result_o = (opb_q == '0) ? '1 : quo_w;
         default:                         result_o = (opb_q == '0) ? rs1_q : rem_w;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_control_md.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_control_md: ALU control decode with stalling iterative RV32M unit
// Rev 1.0
// ------------------------------------------------------------------
module alu_control_md
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   alu_control_md_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] md_result_q, md_result_d, unit_result_w;
   logic            m_op_w, start_w, step_w;
   logic [3:0]      alu_op_w;
   logic            illegal_w;

   assign m_op_w  = ENABLE_M && (bus.ALU_Op_i == OP_R) && (bus.funct7_i == F7_MD);
   assign start_w = (state_q == ST_IDLE) && m_op_w;
   assign step_w  = (state_q == ST_BUSY);

   always_comb begin
      alu_op_w  = ALU_ADD;
      illegal_w = 1'b0;
      case (bus.ALU_Op_i)
         OP_R: begin
            if (m_op_w)
               alu_op_w = ALU_ADD;
            else if (bus.funct7_i == F7_BASE)
               alu_op_w = base_op(bus.funct3_i);
            else if (bus.funct7_i == F7_ALT && bus.funct3_i == 3'b000)
               alu_op_w = ALU_SUB;
            else if (bus.funct7_i == F7_ALT && bus.funct3_i == 3'b101)
               alu_op_w = ALU_SRA;
            else
               illegal_w = 1'b1;
         end
         OP_I: begin
            if (bus.funct3_i == 3'b001) begin
               if (bus.funct7_i == F7_BASE) alu_op_w = ALU_SLL;
               else                         illegal_w = 1'b1;
            end else if (bus.funct3_i == 3'b101) begin
               if (bus.funct7_i == F7_BASE)     alu_op_w = ALU_SRL;
               else if (bus.funct7_i == F7_ALT) alu_op_w = ALU_SRA;
               else                             illegal_w = 1'b1;
            end else begin
               alu_op_w = base_op(bus.funct3_i);
            end
         end
         OP_LUI:        alu_op_w  = ALU_PASSB;
         OP_BR:         alu_op_w  = ALU_SUB;
         OP_LS, OP_JMP: alu_op_w  = ALU_ADD;
         default:       illegal_w = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      md_result_d = md_result_q;
      case (state_q)
         ST_IDLE: begin
            if (m_op_w) begin
               state_d = ST_BUSY;
               cnt_d   = CW'(XLEN - 1);
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_DONE: begin
            // Core retires on this edge, so never linger and re-issue
            md_result_d = unit_result_w;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         md_result_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_result_q <= md_result_d;
      end
   end

   generate
      if (ENABLE_M) begin : g_md
         md_iter_unit #(.XLEN(XLEN)) u_md (
            .clk      (clk),
            .reset    (reset),
            .start_i  (start_w),
            .step_i   (step_w),
            .funct3_i (bus.funct3_i),
            .rs1_i    (bus.rs1_data_i),
            .rs2_i    (bus.rs2_data_i),
            .result_o (unit_result_w)
         );
      end else begin : g_no_md
         assign unit_result_w = '0;
      end
   endgenerate

   assign bus.ALU_Operation_o = alu_op_w;
   assign bus.illegal_o       = illegal_w;
   assign bus.md_select_o     = (state_q == ST_DONE);
   assign bus.md_result_o     = (state_q == ST_DONE) ? unit_result_w : md_result_q;
   assign bus.stall_o         = (state_q == ST_BUSY) || (start_w && !reset);
endmodule
`default_nettype wire

// File: tb/tb_alu_control_md.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_control_md: decode table checks and scoreboarded M-op results
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_control_md;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] exp_q[$];

   alu_control_md_if #(.XLEN(32)) bus ();

   alu_control_md #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ps;
      logic [63:0]        ua, ub, pu;
      logic [31:0]        r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      ps = sa * sb;
      pu = ua * ub;
      case (f3)
         MD_MUL:    r = pu[31:0];
         MD_MULH:   r = ps[63:32];
         MD_MULHSU: begin ps = sa * $signed(ub); r = ps[63:32]; end
         MD_MULHU:  r = pu[63:32];
         MD_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b));
         MD_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         MD_REM:    r = (b == 0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'($signed(a) % $signed(b));
         default:   r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      bus.ALU_Op_i   = op;
      bus.funct7_i   = f7;
      bus.funct3_i   = f3;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
   endtask

   // Called at negedge+1; from_done means the current cycle is a DONE cycle
   task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit from_done, input bit chain);
      int n;
      exp_q.push_back(exp);
      drive(OP_R, F7_MD, f3, a, b);
      if (from_done) begin
         @(negedge clk);
      end
      #1;
      n = 0;
      while (bus.stall_o && n < 200) begin
         n++;
         @(negedge clk);
         if (n == 3) begin
            bus.rs1_data_i = $urandom;
            bus.rs2_data_i = $urandom;
         end
         #1;
      end
      chk("stall_cycles", 32'(n), 32'd33);
      chk("md_select_done", {31'b0, bus.md_select_o}, 32'd1);
      chk("stall_done", {31'b0, bus.stall_o}, 32'd0);
      chk("md_result", bus.md_result_o, exp_q.pop_front());
      if (!chain) begin
         drive(OP_R, F7_BASE, 3'b000, 32'h0, 32'h0);
         @(negedge clk);
         #1;
         chk("md_select_after", {31'b0, bus.md_select_o}, 32'd0);
         chk("md_result_hold", bus.md_result_o, exp);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [3:0] exp_op;
      logic       exp_ill;
   } dec_t;

   dec_t dec_tab[13];

   initial begin
      logic [31:0] a, b;
      dec_tab[0]  = '{OP_R,   7'b0100000, 3'b101, 4'b0111, 1'b0};
      dec_tab[1]  = '{OP_I,   7'b0100000, 3'b001, 4'b0000, 1'b1};
      dec_tab[2]  = '{OP_R,   7'b0000000, 3'b011, 4'b1001, 1'b0};
      dec_tab[3]  = '{OP_R,   7'b0100000, 3'b000, 4'b0001, 1'b0};
      dec_tab[4]  = '{OP_R,   7'b0100000, 3'b010, 4'b0000, 1'b1};
      dec_tab[5]  = '{OP_I,   7'b0100000, 3'b101, 4'b0111, 1'b0};
      dec_tab[6]  = '{OP_I,   7'b0000000, 3'b101, 4'b0110, 1'b0};
      dec_tab[7]  = '{OP_I,   7'b1111111, 3'b110, 4'b0011, 1'b0};
      dec_tab[8]  = '{OP_LUI, 7'b0000000, 3'b000, 4'b1010, 1'b0};
      dec_tab[9]  = '{OP_BR,  7'b0000000, 3'b001, 4'b0001, 1'b0};
      dec_tab[10] = '{OP_LS,  7'b0000000, 3'b010, 4'b0000, 1'b0};
      dec_tab[11] = '{OP_JMP, 7'b0000000, 3'b000, 4'b0000, 1'b0};
      dec_tab[12] = '{3'b110, 7'b0000000, 3'b000, 4'b0000, 1'b1};

      drive(OP_R, F7_BASE, 3'b000, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", {31'b0, bus.stall_o}, 32'd0);
      chk("rst_md_select", {31'b0, bus.md_select_o}, 32'd0);
      chk("rst_md_result", bus.md_result_o, 32'h0);
      reset = 1'b0;

      foreach (dec_tab[i]) begin
         @(negedge clk);
         drive(dec_tab[i].op, dec_tab[i].f7, dec_tab[i].f3, 32'h1234, 32'h5678);
         #1;
         chk($sformatf("dec_op%0d", i), {28'b0, bus.ALU_Operation_o}, {28'b0, dec_tab[i].exp_op});
         chk($sformatf("dec_ill%0d", i), {31'b0, bus.illegal_o}, {31'b0, dec_tab[i].exp_ill});
         chk($sformatf("dec_stall%0d", i), {31'b0, bus.stall_o}, 32'd0);
      end
      @(negedge clk);
      drive(OP_R, F7_BASE, 3'b000, 32'h0, 32'h0);
      #1;

      run_md(MD_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
      drive(OP_R, F7_MD, MD_MULH, 32'h0, 32'h0);
      #1;
      chk("m_op_alu", {28'b0, bus.ALU_Operation_o}, 32'h0);
      chk("m_op_ill", {31'b0, bus.illegal_o}, 32'd0);
      run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_md(MD_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      run_md(MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
      run_md(MD_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_md(MD_REMU,  32'd5,         32'd0,         32'd5,         1'b0, 1'b0);
      run_md(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_md(MD_REM,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, 1'b0);

      // Reset ten cycles into BUSY discards the partial result
      drive(OP_R, F7_MD, MD_DIV, 32'd100, 32'd7);
      repeat (11) @(negedge clk);
      #1;
      chk("busy_stall", {31'b0, bus.stall_o}, 32'd1);
      reset = 1'b1;
      drive(OP_R, F7_BASE, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      chk("rst_busy_stall", {31'b0, bus.stall_o}, 32'd0);
      chk("rst_busy_select", {31'b0, bus.md_select_o}, 32'd0);
      chk("rst_busy_result", bus.md_result_o, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      run_md(MD_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

      run_md(MD_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b1);
      run_md(MD_MUL, 32'd5, 32'd6, 32'd30, 1'b1, 1'b0);

      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = (k == 5) ? 32'd0 : $urandom;
         if (k[0]) b = b >> (k * 3);
         run_md(3'(k), a, b, md_model(3'(k), a, b), 1'b0, 1'b0);
      end

      if (exp_q.size() != 0) chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
